// File: rtl/tm1640_frame_ctrl.sv
// Frame sequencer for a byte-level TM1640 driver. It snapshots a hex display image
// and streams the data command, the address command, the segment bytes and the display control.

module tm1640_frame_ctrl #(
  parameter int NUM_DIGITS     = 9,
  parameter int REFRESH_CYCLES = 0,
  parameter int CNT_W          = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [2:0]              bright,
  input  logic                    disp_on,
  input  logic                    update,
  input  logic                    tm_busy,
  output logic                    tm_latch,
  output logic [7:0]              tm_byte,
  output logic                    tm_end,
  output logic                    ready,
  output logic                    frame_done
);

  localparam int IDX_W = 5;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DIGITS + 2);
  localparam logic [IDX_W-1:0] LAST_DIG_IDX = IDX_W'(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] REF_LAST     = CNT_W'(REFRESH_CYCLES - 1);

  localparam logic [7:0] CMD_DATA = 8'h40;  // write data, auto-increment, normal mode
  localparam logic [7:0] CMD_ADDR = 8'hC0;  // start at address 0
  localparam logic [7:0] CMD_DISP = 8'h80;  // display control, display off
  localparam logic [7:0] DISP_ON  = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [2:0]              snap_bright;
  logic                    snap_on;

  logic [IDX_W-1:0]        sel_idx;
  logic [DIG_W-1:0]        dsel;
  logic [3:0]              nib;
  logic [7:0]              seg_byte;
  logic [7:0]              ctrl_byte;
  logic [7:0]              nxt_byte;
  logic                    nxt_end;
  logic                    refresh_hit;
  logic                    go;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
    endcase
  endfunction

  // The byte for the next latch is computed one cycle ahead. A latch can then leave LOAD or
  // WAIT_DONE directly, and an update lands its first byte two cycles later.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_idx   = idx;
    nxt_byte  = CMD_DATA;
    nxt_end   = 1'b1;
    if (state == S_LOAD) begin
      sel_idx = '0;
    end else if (state == S_WAIT_DONE) begin
      sel_idx = idx + IDX_W'(1);
    end

    dsel      = DIG_W'(sel_idx - IDX_W'(2));
    nib       = snap_digits[{dsel, 2'b00} +: 4];
    seg_byte  = snap_blank[dsel] ? 8'h00 : {snap_dp[dsel], hex_seg(nib)};
    ctrl_byte = snap_on ? (CMD_DISP | DISP_ON | {5'b0, snap_bright}) : CMD_DISP;

    if (sel_idx == '0) begin
      nxt_byte = CMD_DATA;
      nxt_end  = 1'b1;
    end else if (sel_idx == IDX_W'(1)) begin
      nxt_byte = CMD_ADDR;
      nxt_end  = 1'b0;
    end else if (sel_idx == LAST_IDX) begin
      nxt_byte = ctrl_byte;
      nxt_end  = 1'b1;
    end else begin
      nxt_byte = seg_byte;
      nxt_end  = (sel_idx == LAST_DIG_IDX);
    end

    refresh_hit = (REFRESH_CYCLES > 0) && (cnt == REF_LAST);
    go          = pending || update || refresh_hit;
  end

  assign ready = (state == S_IDLE) && !pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshot is a handful of flops, so it is reset along with the control state.
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      pending     <= 1'b1;
      tm_latch    <= 1'b0;
      tm_byte     <= 8'h00;
      tm_end      <= 1'b0;
      frame_done  <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_bright <= '0;
      snap_on     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout. The later pending/cnt assignments below override these defaults.
      tm_latch   <= 1'b0;
      frame_done <= 1'b0;
      if (update) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (go) begin
            state       <= S_LOAD;
            pending     <= 1'b0;
            cnt         <= '0;
            snap_digits <= digits;
            snap_dp     <= dp;
            snap_blank  <= blank;
            snap_bright <= bright;
            snap_on     <= disp_on;
          end else if (REFRESH_CYCLES > 0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_LOAD: begin
          idx <= '0;
          cnt <= '0;
          if (!tm_busy) begin
            tm_latch <= 1'b1;
            tm_byte  <= nxt_byte;
            tm_end   <= nxt_end;
            state    <= S_WAIT_ACK;
          end else begin
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cnt <= '0;
          if (!tm_busy) begin
            tm_latch <= 1'b1;
            tm_byte  <= nxt_byte;
            tm_end   <= nxt_end;
            state    <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          cnt <= '0;
          if (tm_busy) state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          cnt <= '0;
          if (!tm_busy) begin
            if (idx == LAST_IDX) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              idx      <= idx + IDX_W'(1);
              tm_latch <= 1'b1;
              tm_byte  <= nxt_byte;
              tm_end   <= nxt_end;
              state    <= S_WAIT_ACK;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
